// File: rtl/sigma_delta_pkg.sv
// Shared types and helpers for the sigma-delta converter family (DAC and ADC
// use the same modulator-order enum so one configuration drives both).
package sigma_delta_pkg;

  typedef enum logic [0:0] {
    MOD_O1 = 1'b0,
    MOD_O2 = 1'b1
  } mod_order_t;

  // Frame counter width for a power-of-two oversampling rate.
  function automatic int rate_log2(input int rate);
    return $clog2(rate);
  endfunction

  function automatic mod_order_t to_mod_order(input int order);
    return (order == 2) ? MOD_O2 : MOD_O1;
  endfunction

  // Two's complement to offset binary is just an MSB flip within the sample width.
  function automatic logic [31:0] to_offset_binary(input logic [31:0] sample,
                                                   input int          width,
                                                   input logic        signed_en);
    logic [31:0] mask;
    mask = 32'd1 << (width - 1);
    return signed_en ? (sample ^ mask) : sample;
  endfunction

endpackage

// File: rtl/sigma_delta_modulator.sv
// Noise-shaping loop: turns an N-bit unsigned level x into a 1-bit stream whose
// average is x/2^N. Order 1 is a carry accumulator, order 2 uses error feedback.
module sigma_delta_modulator
  import sigma_delta_pkg::*;
#(
  parameter int MOD_ORDER = 1,
  parameter int N         = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  output logic         pin
);
  localparam mod_order_t ORDER = to_mod_order(MOD_ORDER);

  generate
    if (ORDER == MOD_O2) begin : g_order2
      localparam logic signed [N+2:0] HALF = (N+3)'(2 ** (N - 1));
      localparam logic signed [N+2:0] FULL = (N+3)'(2 ** N);

      logic signed [N+2:0] e1_reg;
      logic signed [N+2:0] e2_reg;
      logic signed [N+2:0] v;
      logic signed [N+2:0] e_new;
      logic                q;

      // Three guard bits keep x + 2*e1 - e2 exact for errors bounded by 2^N.
      assign v     = $signed({3'b000, x}) + (e1_reg <<< 1) - e2_reg;
      assign q     = (v >= HALF);
      assign e_new = q ? (v - FULL) : v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          e1_reg <= '0;
          e2_reg <= '0;
          pin    <= 1'b0;
        end else begin
          e2_reg <= e1_reg;
          e1_reg <= e_new;
          pin    <= q;
        end
      end
    end else begin : g_order1
      logic [N-1:0] acc_reg;
      logic [N:0]   sum;

      assign sum = {1'b0, acc_reg} + {1'b0, x};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg <= '0;
          pin     <= 1'b0;
        end else begin
          acc_reg <= sum[N-1:0];
          pin     <= sum[N];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sigma_delta_dac.sv
// Sigma-delta DAC: one-deep sample buffer, frame counter and linear
// interpolator feeding the 1-bit noise-shaping modulator.
module sigma_delta_dac
  import sigma_delta_pkg::*;
#(
  parameter int OVERSAMPLE_RATE = 256,
  parameter int DAC_BITLEN      = 16,
  parameter bit SIGNED_INPUT    = 1'b1,
  parameter bit INTERP_ENABLE   = 1'b1,
  parameter int MOD_ORDER       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_BITLEN-1:0] dac_input,
  input  logic                  dac_valid,
  output logic                  dac_ready,
  output logic                  dac_pin,
  output logic                  dac_underrun
);
  localparam int N  = DAC_BITLEN;
  localparam int K  = rate_log2(OVERSAMPLE_RATE);
  localparam int LW = N + K + 1;
  localparam logic [N-1:0] MID     = {1'b1, {(N-1){1'b0}}};
  localparam logic [K-1:0] PH_LAST = K'(OVERSAMPLE_RATE - 1);

  logic [K-1:0]           ph_reg;
  logic                   pend_full_reg;
  logic [N-1:0]           pend_reg;
  logic [N-1:0]           nxt_reg;
  logic signed [LW-1:0]   lev_reg;
  logic signed [N:0]      step_reg;

  logic                   tick;
  logic                   accept;
  logic [N-1:0]           sample_u;
  logic [N-1:0]           new_nxt;
  logic signed [N:0]      new_step;
  logic [N-1:0]           x;

  assign tick         = (ph_reg == PH_LAST);
  assign dac_ready    = !pend_full_reg && !rst;
  assign accept       = dac_valid && dac_ready;
  assign dac_underrun = tick && !pend_full_reg && !rst;

  assign sample_u = N'(to_offset_binary(32'(dac_input), N, SIGNED_INPUT));

  // The outgoing nxt becomes the new cur; its value lives on as lev's reload base.
  assign new_nxt  = pend_full_reg ? pend_reg : nxt_reg;
  assign new_step = INTERP_ENABLE ? ($signed({1'b0, new_nxt}) - $signed({1'b0, nxt_reg}))
                                  : '0;

  // lev never leaves [0, (2^N-1)*2^K] across a frame, so its integer part fits N bits.
  assign x = lev_reg[K +: N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_reg        <= '0;
      pend_full_reg <= 1'b0;
      pend_reg      <= '0;
      nxt_reg       <= MID;
      lev_reg       <= $signed({1'b0, MID, {K{1'b0}}});
      step_reg      <= '0;
    end else begin
      ph_reg <= ph_reg + K'(1);

      if (tick) begin
        nxt_reg  <= new_nxt;
        lev_reg  <= $signed({1'b0, nxt_reg, {K{1'b0}}});
        step_reg <= new_step;
      end else begin
        lev_reg <= lev_reg + $signed({{K{step_reg[N]}}, step_reg});
      end

      // A same-cycle accept lands after the tick has already consumed pend.
      if (accept) begin
        pend_reg      <= sample_u;
        pend_full_reg <= 1'b1;
      end else if (tick) begin
        pend_full_reg <= 1'b0;
      end
    end
  end

  sigma_delta_modulator #(
    .MOD_ORDER(MOD_ORDER),
    .N        (N)
  ) u_modulator (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .pin(dac_pin)
  );

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Bench for sigma_delta_dac: a frame-level reference model checks handshake,
// underrun and bitstream every cycle; extra instances cover order 2 and a long ramp.
module tb_sigma_delta_dac;
  localparam int N    = 16;
  localparam int OSR  = 256;
  localparam int K    = 8;
  localparam int OSR3 = 4096;
  localparam int MID  = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, dac_valid, dac_ready, dac_pin, dac_underrun;
  logic [N-1:0] dac_input;
  logic         rst_aux, valid2, ready2, pin2, und2, valid3, ready3, pin3, und3;
  logic [N-1:0] in2, in3;

  int tests = 0;
  int fails = 0;
  int n_accepts = 0;

  sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .DAC_BITLEN(N), .SIGNED_INPUT(1'b1),
                    .INTERP_ENABLE(1'b1), .MOD_ORDER(1)) dut (
    .clk(clk), .rst(rst), .dac_input(dac_input), .dac_valid(dac_valid),
    .dac_ready(dac_ready), .dac_pin(dac_pin), .dac_underrun(dac_underrun));

  sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .DAC_BITLEN(N), .SIGNED_INPUT(1'b1),
                    .INTERP_ENABLE(1'b0), .MOD_ORDER(2)) dut2 (
    .clk(clk), .rst(rst_aux), .dac_input(in2), .dac_valid(valid2),
    .dac_ready(ready2), .dac_pin(pin2), .dac_underrun(und2));

  sigma_delta_dac #(.OVERSAMPLE_RATE(OSR3), .DAC_BITLEN(N), .SIGNED_INPUT(1'b0),
                    .INTERP_ENABLE(1'b1), .MOD_ORDER(1)) dut3 (
    .clk(clk), .rst(rst_aux), .dac_input(in3), .dac_valid(valid3),
    .dac_ready(ready3), .dac_pin(pin3), .dac_underrun(und3));

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: frame-level cur/nxt/pend, x as the ideal linear ramp, and the
  // order-1 stream as the increments of floor(running sum of x / 2^N).
  int     m_ph = 0, m_pend_full = 0, m_pend = 0, m_cur = MID, m_nxt = MID, m_pin = 0;
  longint m_sum = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_ready", longint'(dac_ready), 0);
        check("reset_pin", longint'(dac_pin), 0);
        check("reset_underrun", longint'(dac_underrun), 0);
        m_ph = 0; m_pend_full = 0; m_pend = 0; m_cur = MID; m_nxt = MID;
        m_pin = 0; m_sum = 0;
      end else begin
        longint x, s_new;
        int exp_ready, exp_und;
        exp_ready = (m_pend_full == 0) ? 1 : 0;
        exp_und   = (m_ph == OSR - 1 && m_pend_full == 0) ? 1 : 0;
        check("ready", longint'(dac_ready), exp_ready);
        check("underrun", longint'(dac_underrun), exp_und);
        check("pin", longint'(dac_pin), m_pin);
        x = longint'(m_cur) + ((longint'(m_ph) * longint'(m_nxt - m_cur)) >>> K);
        s_new = m_sum + x;
        m_pin = int'(s_new / 65536 - m_sum / 65536);
        m_sum = s_new;
        if (m_ph == OSR - 1) begin
          m_cur = m_nxt;
          if (m_pend_full != 0) begin
            m_nxt = m_pend;
            m_pend_full = 0;
          end
        end
        if (dac_valid && exp_ready == 1) begin
          m_pend = int'(dac_input ^ 16'h8000);
          m_pend_full = 1;
          n_accepts++;
          $display("[TB] accept %0d sample=0x%04h", n_accepts, dac_input);
        end
        m_ph = (m_ph + 1) % OSR;
      end
    end
  end

  task automatic observe(input int cycles, output int ones, output int unds,
                         output int accs, output int reps);
    logic prev;
    ones = 0; unds = 0; accs = 0; reps = 0; prev = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (i > 0 && dac_pin == prev) reps++;
      prev = dac_pin;
      ones += int'(dac_pin);
      unds += int'(dac_underrun);
      accs += int'(dac_valid && dac_ready);
    end
  endtask

  task automatic wait_accept(output int got);
    got = 0;
    for (int i = 0; i < 600 && got == 0; i++) begin
      @(negedge clk);
      got = int'(dac_valid && dac_ready);
    end
  endtask

  task automatic main_seq();
    int ones, unds, accs, reps, got;
    logic [N-1:0] val;
    // Idle after reset: midscale, alternating stream, underrun every frame.
    repeat (2) @(negedge clk);
    observe(1024, ones, unds, accs, reps);
    check("idle_ones_1024", ones, 512);
    check("idle_underruns", unds, 4);
    check("idle_pin_repeats", reps, 0);

    // Constant signed 0x4000 streamed without gaps.
    @(posedge clk); #2;
    dac_valid = 1'b1; dac_input = 16'h4000;
    observe(768, ones, unds, accs, reps);
    check("stream_underruns", unds, 0);
    check("stream_accepts", accs, 4);
    observe(256, ones, unds, accs, reps);
    check("stream_ones_frame", ones, 192);

    // Incrementing sequence with dac_valid held high.
    val = 16'h1000; accs = 0; unds = 0;
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #2;
      dac_input = val;
      @(negedge clk);
      if (dac_valid && dac_ready) begin
        accs++;
        val = val + 16'h0900;
      end
      unds += int'(dac_underrun);
    end
    check("incr_accepts", accs, 4);
    check("incr_underruns", unds, 0);

    // Random offers with sparse and dense phases.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      dac_valid = ($urandom_range(0, 99) < ((i < 1500) ? 1 : 8));
      dac_input = 16'($urandom);
    end

    // Mid-frame reset with pend_full set and the pin high.
    @(posedge clk); #2;
    dac_valid = 1'b1; dac_input = 16'h7000;
    for (int k = 0; k < 3; k++) begin
      wait_accept(got);
      check("rst_prep_accept", got, 1);
    end
    @(posedge clk); #2;
    dac_valid = 1'b0;
    check("rst_prep_pend_full", longint'(dac_ready), 0);
    for (int i = 0; i < 16 && dac_pin !== 1'b1; i++) begin
      @(posedge clk); #2;
    end
    check("rst_prep_pin_high", longint'(dac_pin), 1);
    rst = 1'b1;
    #1;
    check("async_rst_pin", longint'(dac_pin), 0);
    check("async_rst_ready", longint'(dac_ready), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("ready_after_release", longint'(dac_ready), 1);
    repeat (2) @(negedge clk);
    observe(256, ones, unds, accs, reps);
    check("post_rst_ones", ones, 128);
    check("post_rst_underruns", unds, 1);
    check("post_rst_pin_repeats", reps, 0);
  endtask

  task automatic aux_seq();
    int ones2 = 0, acc2 = 0, und2n = 0, ones3 = 0;
    for (int c = 0; c < 12300; c++) begin
      @(negedge clk);
      if (c >= 1024 && c < 2048) begin
        ones2 += int'(pin2);
        acc2  += int'(valid2 && ready2);
        und2n += int'(und2);
      end
      if (c >= 8193 && c <= 12288) ones3 += int'(pin3);
      if (c == 0) check("ramp_first_ready", longint'(ready3), 1);
      if (c == 1) valid3 = 1'b0;
      if (c == 4095) begin
        check("ramp_ready_before_tick", longint'(ready3), 0);
        check("ramp_no_underrun_4095", longint'(und3), 0);
        valid3 = 1'b1; in3 = 16'hFFFF;
      end
      if (c == 4096) check("ramp_ready_after_tick", longint'(ready3), 1);
      if (c == 4097) valid3 = 1'b0;
      if (c == 8191) check("ramp_no_underrun_8191", longint'(und3), 0);
      if (c == 12287) check("ramp_underrun_empty", longint'(und3), 1);
    end
    check_range("o2_ones_1024", ones2, 510, 514);
    check("o2_accepts", acc2, 4);
    check("o2_underruns", und2n, 0);
    check_range("ramp_ones", ones3, 2047, 2048);
  endtask

  initial begin
    rst = 1'b1; dac_valid = 1'b0; dac_input = '0;
    rst_aux = 1'b1; valid2 = 1'b0; in2 = '0; valid3 = 1'b0; in3 = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0; rst_aux = 1'b0; valid2 = 1'b1; valid3 = 1'b1;
    fork
      main_seq();
      aux_seq();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
